// File: rtl/biquad_pkg.sv
// Shared types and constants for the time-multiplexed lowpass biquad scheduler.
// Coefficients are Q30 (2^30 = 1.0); denominator sign is folded so y terms are added.
package biquad_pkg;

  localparam int     COEF_W  = 64;
  localparam longint SAT_MAX = 32767;
  localparam longint SAT_MIN = -32768;

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  typedef struct packed {
    logic signed [COEF_W-1:0] b0;
    logic signed [COEF_W-1:0] b1;
    logic signed [COEF_W-1:0] b2;
    logic signed [COEF_W-1:0] a1;
    logic signed [COEF_W-1:0] a2;
  } coeff_set_t;

  // 0 bypass, then Butterworth-style lowpass at 1k / 2.5k / 5k / 10k (fs 48k)
  localparam coeff_set_t [0:4] COEFFS = '{
    '{b0: 64'sd1073741824, b1: 64'sd0,         b2: 64'sd0,
      a1: 64'sd0,          a2: 64'sd0},
    '{b0: 64'sd4204896,    b1: 64'sd8409792,   b2: 64'sd4204896,
      a1: 64'sd1949485656, a2: -64'sd892285576},
    '{b0: 64'sd23215372,   b1: 64'sd46430744,  b2: 64'sd23215372,
      a1: 64'sd1656914630, a2: -64'sd676031074},
    '{b0: 64'sd77557446,   b1: 64'sd155114892, b2: 64'sd77557446,
      a1: 64'sd1191024496, a2: -64'sd427512455},
    '{b0: 64'sd236432581,  b1: 64'sd472865162, b2: 64'sd236432581,
      a1: 64'sd330247551,  a2: -64'sd202233904}
  };

endpackage

// File: rtl/biquad_coeff_rom.sv
// Combinational coefficient lookup: preset and tap index select one Q30 coefficient.
module biquad_coeff_rom import biquad_pkg::*; (
  input  logic [2:0]               filter_active_i,
  input  logic [2:0]               tap_i,
  output logic signed [COEF_W-1:0] coeff_o
);

  coeff_set_t cs;

  always_comb begin
    case (filter_active_i)
      3'd1:    cs = COEFFS[1];
      3'd2:    cs = COEFFS[2];
      3'd3:    cs = COEFFS[3];
      3'd4:    cs = COEFFS[4];
      default: cs = COEFFS[0];
    endcase
    case (tap_i)
      3'd0:    coeff_o = cs.b0;
      3'd1:    coeff_o = cs.b1;
      3'd2:    coeff_o = cs.b2;
      3'd3:    coeff_o = cs.a1;
      default: coeff_o = cs.a2;
    endcase
  end

endmodule

// File: rtl/biquad_scheduler.sv
// Shares one signed multiplier across CH biquad channels: 5 MAC taps + 1 write per channel.
// Optional macro BIQUAD_SAT_COUNT_EN adds the sat_count output (saturating clip counter).
module biquad_scheduler import biquad_pkg::*; #(
  parameter int CH    = 2,
  parameter int W     = 16,
  parameter int ACC   = 64,
  parameter int SHIFT = 30
) (
  input  logic            clk_144,
  input  logic            reset_n,
  input  logic            sample_strobe,
  input  logic [CH*W-1:0] in_data,
  input  logic [2:0]      filter_sel,
  output logic            busy,
  output logic            out_valid,
  output logic [CH*W-1:0] out_data,
  output logic [2:0]      filter_active,
  output logic            overrun
`ifdef BIQUAD_SAT_COUNT_EN
  ,
  output logic [15:0]     sat_count
`endif
);

  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  state_t                  state_q, state_d;
  logic [CHW-1:0]          ch_q, ch_d;
  logic [2:0]              tap_q, tap_d;
  logic signed [ACC-1:0]   acc_q, acc_d;
  logic [CH-1:0][W-1:0]    x0_q, x1_q, x2_q, y1_q, y2_q, out_q;
  logic [2:0]              fa_q, sel_m;
  logic                    ovr_q, vld_q;
  logic                    capture, wr_en, last_wr;

  logic signed [W-1:0]      op, res;
  logic signed [COEF_W-1:0] coeff;
  logic signed [ACC-1:0]    op_ext, coeff_ext, prod, term;
  logic                     sat_hi, sat_lo;

  biquad_coeff_rom u_rom (
    .filter_active_i(fa_q),
    .tap_i          (tap_q),
    .coeff_o        (coeff)
  );

  always_comb begin
    case (tap_q)
      3'd0:    op = x0_q[ch_q];
      3'd1:    op = x1_q[ch_q];
      3'd2:    op = x2_q[ch_q];
      3'd3:    op = y1_q[ch_q];
      default: op = y2_q[ch_q];
    endcase
  end

  assign op_ext    = ACC'(op);
  assign coeff_ext = ACC'(coeff);
  assign prod      = op_ext * coeff_ext;
  assign term      = prod >>> SHIFT;

  assign sat_hi = acc_q > ACC'(SAT_MAX);
  assign sat_lo = acc_q < ACC'(SAT_MIN);
  assign res    = sat_hi ? W'(SAT_MAX) : sat_lo ? W'(SAT_MIN) : acc_q[W-1:0];

  // Presets 5-7 are unassigned and behave as bypass
  assign sel_m = (filter_sel > 3'd4) ? 3'd0 : filter_sel;

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tap_d   = tap_q;
    acc_d   = acc_q;
    capture = 1'b0;
    wr_en   = 1'b0;
    last_wr = 1'b0;
    case (state_q)
      IDLE: if (sample_strobe) begin
        capture = 1'b1;
        state_d = MAC;
        ch_d    = '0;
        tap_d   = '0;
      end
      MAC: begin
        acc_d = ((tap_q == 3'd0) ? '0 : acc_q) + term;
        if (tap_q == 3'd4) begin
          tap_d   = '0;
          state_d = WRITE;
        end else begin
          tap_d = tap_q + 3'd1;
        end
      end
      WRITE: begin
        wr_en = 1'b1;
        if (ch_q == CHW'(CH-1)) begin
          state_d = IDLE;
          last_wr = 1'b1;
        end else begin
          ch_d    = ch_q + CHW'(1);
          state_d = MAC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tap_q   <= '0;
      acc_q   <= '0;
      x0_q    <= '0;
      x1_q    <= '0;
      x2_q    <= '0;
      y1_q    <= '0;
      y2_q    <= '0;
      out_q   <= '0;
      fa_q    <= '0;
      ovr_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tap_q   <= tap_d;
      acc_q   <= acc_d;
      vld_q   <= last_wr;
      if (sample_strobe && state_q != IDLE) ovr_q <= 1'b1;
      if (capture) begin
        x0_q <= in_data;
        fa_q <= sel_m;
        // A preset change makes old history meaningless for the new filter
        if (sel_m != fa_q) begin
          x1_q <= '0;
          x2_q <= '0;
          y1_q <= '0;
          y2_q <= '0;
        end
      end
      if (wr_en) begin
        out_q[ch_q] <= res;
        y1_q[ch_q]  <= res;
        y2_q[ch_q]  <= y1_q[ch_q];
        x2_q[ch_q]  <= x1_q[ch_q];
        x1_q[ch_q]  <= x0_q[ch_q];
      end
    end
  end

`ifdef BIQUAD_SAT_COUNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk_144 or negedge reset_n) begin
    if (!reset_n) sat_cnt_q <= '0;
    else if (wr_en && (sat_hi || sat_lo) && sat_cnt_q != 16'hFFFF)
      sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`endif

  assign busy          = (state_q != IDLE);
  assign out_valid     = vld_q;
  assign out_data      = out_q;
  assign filter_active = fa_q;
  assign overrun       = ovr_q;

endmodule

// File: tb/tb_biquad_scheduler.sv
// Bench for biquad_scheduler: hand vectors, overrun/reset sequences, random samples vs a reference filter.
module tb_biquad_scheduler;

  localparam int CH = 2;
  localparam int W  = 16;

  logic            clk_144 = 1'b0;
  logic            reset_n = 1'b0;
  logic            sample_strobe = 1'b0;
  logic [CH*W-1:0] in_data = '0;
  logic [2:0]      filter_sel = '0;
  logic            busy, out_valid, overrun;
  logic [CH*W-1:0] out_data;
  logic [2:0]      filter_active;
`ifdef BIQUAD_SAT_COUNT_EN
  logic [15:0]     sat_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk_144 = ~clk_144;

  biquad_scheduler #(.CH(CH), .W(W), .ACC(64), .SHIFT(30)) dut (
    .clk_144      (clk_144),
    .reset_n      (reset_n),
    .sample_strobe(sample_strobe),
    .in_data      (in_data),
    .filter_sel   (filter_sel),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .filter_active(filter_active),
    .overrun      (overrun)
`ifdef BIQUAD_SAT_COUNT_EN
    ,
    .sat_count    (sat_count)
`endif
  );

  // Reference filter: Q30 presets, rows b0 b1 b2 a1 a2 (a terms added)
  longint ctab [0:4][0:4] = '{
    '{1073741824, 0, 0, 0, 0},
    '{4204896, 8409792, 4204896, 1949485656, -892285576},
    '{23215372, 46430744, 23215372, 1656914630, -676031074},
    '{77557446, 155114892, 77557446, 1191024496, -427512455},
    '{236432581, 472865162, 236432581, 330247551, -202233904}
  };
  longint mx1 [CH], mx2 [CH], my1 [CH], my2 [CH], mout [CH];
  int     mfa, msat;

  function automatic void model_reset();
    for (int c = 0; c < CH; c++) begin
      mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0; mout[c] = 0;
    end
    mfa  = 0;
    msat = 0;
  endfunction

  function automatic void model_step(input int sel, input longint d0, input longint d1);
    int     p;
    longint acc, y;
    longint xv [CH];
    p = (sel > 4) ? 0 : sel;
    if (p != mfa)
      for (int c = 0; c < CH; c++) begin
        mx1[c] = 0; mx2[c] = 0; my1[c] = 0; my2[c] = 0;
      end
    mfa   = p;
    xv[0] = d0;
    xv[1] = d1;
    for (int c = 0; c < CH; c++) begin
      acc = ((ctab[p][0] * xv[c]) >>> 30) + ((ctab[p][1] * mx1[c]) >>> 30)
          + ((ctab[p][2] * mx2[c]) >>> 30) + ((ctab[p][3] * my1[c]) >>> 30)
          + ((ctab[p][4] * my2[c]) >>> 30);
      y = (acc > 32767) ? 32767 : (acc < -32768) ? -32768 : acc;
      if (y != acc) msat++;
      mout[c] = y;
      my2[c]  = my1[c];
      my1[c]  = y;
      mx2[c]  = mx1[c];
      mx1[c]  = xv[c];
    end
  endfunction

  task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic signed [63:0] dout(input int c);
    logic signed [W-1:0] v;
    v = out_data[c*W +: W];
    return 64'(v);
  endfunction

  // Starts at a negedge, ends at the negedge where out_valid is seen (or the bound expires)
  task automatic run_sample(input logic [2:0] sel, input logic signed [W-1:0] d0,
                            input logic signed [W-1:0] d1, input string nm);
    int n, bcnt;
    filter_sel    = sel;
    in_data       = {d1, d0};
    sample_strobe = 1'b1;
    @(negedge clk_144);
    sample_strobe = 1'b0;
    model_step(int'(sel), longint'(d0), longint'(d1));
    n    = 0;
    bcnt = 0;
    while (!out_valid && n < 30) begin
      if (busy) bcnt++;
      @(negedge clk_144);
      n++;
    end
    chk({nm, " latency"}, n, 12);
    chk({nm, " busy cycles"}, bcnt, 12);
    for (int c = 0; c < CH; c++) chk($sformatf("%s ch%0d", nm, c), dout(c), mout[c]);
    chk({nm, " filter_active"}, filter_active, mfa);
  endtask

  typedef struct {
    logic [2:0]          sel;
    logic signed [W-1:0] d0, d1;
    int                  e0, e1, efa;
  } vec_t;

  vec_t vt [8];

  initial begin
    logic [2:0] sel_r;
    int         s0, pulses;
    bit         sat_seen;

    vt[0] = '{3'd0, 16'sd1000,  -16'sd2000, 1000,   -2000, 0};
    vt[1] = '{3'd1, 16'sd16384, 16'sd0,     64,     0,     1};
    vt[2] = '{3'd1, 16'sd0,     16'sd0,     244,    0,     1};
    vt[3] = '{3'd1, 16'sd0,     16'sd0,     453,    0,     1};
    vt[4] = '{3'd2, 16'sd0,     16'sd0,     0,      0,     2};
    vt[5] = '{3'd0, -16'sd32768, 16'sd32767, -32768, 32767, 0};
    vt[6] = '{3'd7, 16'sd5,     -16'sd5,    5,      -5,    0};
    vt[7] = '{3'd1, 16'sd0,     16'sd16384, 0,      64,    1};

    model_reset();
    repeat (3) @(negedge clk_144);
    chk("reset busy", busy, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset out_data", out_data, 0);
    chk("reset filter_active", filter_active, 0);
    chk("reset overrun", overrun, 0);
`ifdef BIQUAD_SAT_COUNT_EN
    chk("reset sat_count", sat_count, 0);
`endif
    reset_n = 1'b1;
    @(negedge clk_144);

    // Back-to-back: each strobe lands in the previous run's out_valid cycle
    for (int i = 0; i < 8; i++) begin
      run_sample(vt[i].sel, vt[i].d0, vt[i].d1, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d tbl ch0", i), dout(0), vt[i].e0);
      chk($sformatf("vec%0d tbl ch1", i), dout(1), vt[i].e1);
      chk($sformatf("vec%0d tbl fa", i), filter_active, vt[i].efa);
    end
    @(negedge clk_144);
    chk("pulse width", out_valid, 0);
    chk("overrun after back-to-back", overrun, 0);

    // Second strobe five cycles into a run is dropped
    filter_sel    = 3'd1;
    in_data       = {16'sd300, 16'sd1200};
    sample_strobe = 1'b1;
    @(negedge clk_144);
    sample_strobe = 1'b0;
    model_step(1, 1200, 300);
    repeat (4) @(negedge clk_144);
    filter_sel    = 3'd3;
    in_data       = {16'sd7, 16'sd7};
    sample_strobe = 1'b1;
    @(negedge clk_144);
    sample_strobe = 1'b0;
    pulses = 0;
    for (int n = 0; n < 20; n++) begin
      if (out_valid) begin
        pulses++;
        chk("ovr data ch0", dout(0), mout[0]);
        chk("ovr data ch1", dout(1), mout[1]);
      end
      @(negedge clk_144);
    end
    chk("ovr pulses", pulses, 1);
    chk("ovr flag", overrun, 1);
    chk("ovr filter_active", filter_active, 1);

    sel_r = 3'd1;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(3) == 0) sel_r = 3'($urandom_range(7));
      run_sample(sel_r, W'($urandom), W'($urandom), $sformatf("rand%0d", i));
    end
    chk("overrun sticky", overrun, 1);

    // Step into the 10k preset until its overshoot clips
    sat_seen = 1'b0;
    for (int i = 0; i < 40 && !sat_seen; i++) begin
      s0 = msat;
      run_sample(3'd4, 16'sd32767, 16'sd0, $sformatf("step%0d", i));
      if (msat != s0) begin
        sat_seen = 1'b1;
        chk("step clip", dout(0), 32767);
      end
    end
`ifdef BIQUAD_SAT_COUNT_EN
    chk("sat_count", sat_count, msat);
`endif

    // Asynchronous reset in the middle of a MAC sequence
    filter_sel    = 3'd1;
    in_data       = {16'sd100, 16'sd100};
    sample_strobe = 1'b1;
    @(negedge clk_144);
    sample_strobe = 1'b0;
    repeat (3) @(negedge clk_144);
    #1 reset_n = 1'b0;
    #1;
    chk("midrun busy", busy, 0);
    chk("midrun out_valid", out_valid, 0);
    chk("midrun out_data", out_data, 0);
    chk("midrun filter_active", filter_active, 0);
    chk("midrun overrun", overrun, 0);
`ifdef BIQUAD_SAT_COUNT_EN
    chk("midrun sat_count", sat_count, 0);
`endif
    model_reset();
    @(negedge clk_144);
    reset_n = 1'b1;
    @(negedge clk_144);
    chk("post reset idle", busy, 0);
    run_sample(3'd0, -16'sd123, 16'sd456, "post");
    chk("post overrun", overrun, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
